// File: rtl/cnn_pkg.sv
// Shared definitions for the IFM fetch path: FSM state encoding and field widths.
package cnn_pkg;

    localparam int DIM_W = 8;   // width of the tile dimension fields
    localparam int K_W   = 4;   // kernel size field width
    localparam int S_W   = 2;   // stride field width
    localparam int P_W   = 2;   // padding field width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } fsm_state_t;

endpackage

// File: rtl/ifm_win_cnt.sv
// Window walker: nested kx/ky/c0/r0 counters in (padded) tile coordinates.
// It keeps two address registers:
//   - win_base_reg: address of the current window row's row 0 (r0 - P)
//   - row_base_reg: address of the row currently being read (r0 + ky - P)
// Both are stepped with additions only. Pixel address = row_base + x - P.
module ifm_win_cnt #(
    parameter int ADDR_WIDTH = 16,
    parameter int CW         = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [ADDR_WIDTH-1:0]   load_base,
    input  logic                    en,
    input  logic [cnn_pkg::K_W-1:0] k,
    input  logic [cnn_pkg::S_W-1:0] s,
    input  logic [ADDR_WIDTH-1:0]   w_step,
    input  logic [ADDR_WIDTH-1:0]   stride_row,
    input  logic [CW-1:0]           wp,
    input  logic [CW-1:0]           hp,
    output logic [CW-1:0]           x,
    output logic [CW-1:0]           y,
    output logic [ADDR_WIDTH-1:0]   row_base,
    output logic                    win_last,
    output logic                    tile_last
);
    import cnn_pkg::*;

    localparam logic [K_W-1:0] K_ONE = 1;

    logic [K_W-1:0]        kx_reg;
    logic [K_W-1:0]        ky_reg;
    logic [CW-1:0]         c0_reg;
    logic [CW-1:0]         r0_reg;
    logic [ADDR_WIDTH-1:0] win_base_reg;
    logic [ADDR_WIDTH-1:0] row_base_reg;

    logic          kx_end;
    logic          ky_end;
    logic          col_end;
    logic          row_end;
    logic [CW-1:0] k_ext;
    logic [CW-1:0] s_ext;

    assign k_ext   = CW'(k);
    assign s_ext   = CW'(s);
    assign kx_end  = (kx_reg == k - K_ONE);
    assign ky_end  = (ky_reg == k - K_ONE);
    // Next window origin would overhang: leftover columns/rows are skipped.
    assign col_end = ((c0_reg + s_ext + k_ext) > wp);
    assign row_end = ((r0_reg + s_ext + k_ext) > hp);

    assign win_last  = kx_end && ky_end;
    assign tile_last = win_last && col_end && row_end;
    assign x         = c0_reg + CW'(kx_reg);
    assign y         = r0_reg + CW'(ky_reg);
    assign row_base  = row_base_reg;

    // Advance the scan position kx -> ky -> c0 -> r0 once per enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kx_reg       <= '0;
            ky_reg       <= '0;
            c0_reg       <= '0;
            r0_reg       <= '0;
            win_base_reg <= '0;
            row_base_reg <= '0;
        end else if (load) begin
            kx_reg       <= '0;
            ky_reg       <= '0;
            c0_reg       <= '0;
            r0_reg       <= '0;
            win_base_reg <= load_base;
            row_base_reg <= load_base;
        end else if (en) begin
            if (!kx_end) begin
                kx_reg <= kx_reg + K_ONE;
            end else begin
                kx_reg <= '0;
                if (!ky_end) begin
                    ky_reg       <= ky_reg + K_ONE;
                    row_base_reg <= row_base_reg + w_step;
                end else begin
                    ky_reg <= '0;
                    if (!col_end) begin
                        c0_reg       <= c0_reg + s_ext;
                        row_base_reg <= win_base_reg;
                    end else begin
                        c0_reg       <= '0;
                        r0_reg       <= r0_reg + s_ext;
                        win_base_reg <= win_base_reg + stride_row;
                        row_base_reg <= win_base_reg + stride_row;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ifm_fetch_ctrl.sv
// IFM fetch controller: walks KxK windows over an H x W tile in SRAM and
// streams one pixel per non-stalled cycle to the IFM buffers.
// Optional feature: define IFM_PAD_EN to add the cfg_pad input (zero padding
// of P pixels on every side); without it the block behaves as P = 0.
module ifm_fetch_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DIM_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   cfg_base,
    input  logic [DIM_W-1:0]        cfg_w,
    input  logic [DIM_W-1:0]        cfg_h,
    input  logic [cnn_pkg::K_W-1:0] cfg_k,
    input  logic [cnn_pkg::S_W-1:0] cfg_stride,
`ifdef IFM_PAD_EN
    input  logic [cnn_pkg::P_W-1:0] cfg_pad,
`endif
    input  logic                    stall,
    output logic                    sram_rd_en,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    input  logic [DATA_WIDTH-1:0]   sram_rd_data,
    output logic                    set_ifm,
    output logic [DATA_WIDTH-1:0]   ifm_in,
    output logic                    win_last,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);
    import cnn_pkg::*;

    localparam int CW = DIM_W + 2;
    localparam int AW = ADDR_WIDTH;

    // ---------------- configuration at start ----------------
    logic [P_W-1:0] pad_in;
`ifdef IFM_PAD_EN
    assign pad_in = cfg_pad;
`else
    assign pad_in = '0;
`endif

    logic [CW-1:0] wp_in;
    logic [CW-1:0] hp_in;
    logic [CW-1:0] k_in;
    logic          cfg_legal;
    logic [AW-1:0] w_in_ext;
    logic [AW-1:0] pad_rows_off;
    logic [AW-1:0] init_base;

    assign wp_in     = CW'(cfg_w) + CW'({pad_in, 1'b0});
    assign hp_in     = CW'(cfg_h) + CW'({pad_in, 1'b0});
    assign k_in      = CW'(cfg_k);
    assign cfg_legal = (cfg_k != '0) && (cfg_stride != '0) &&
                       (k_in <= wp_in) && (k_in <= hp_in);

    // Address of padded pixel (0,0) row: base - P*W, via shift-add (P is 2 bits).
    assign w_in_ext     = AW'(cfg_w);
    assign pad_rows_off = (pad_in[0] ? w_in_ext : '0) + (pad_in[1] ? (w_in_ext << 1) : '0);
    assign init_base    = cfg_base - pad_rows_off;

    fsm_state_t     state_reg;
    logic [DIM_W-1:0] w_reg;
    logic [DIM_W-1:0] h_reg;
    logic [K_W-1:0] k_reg;
    logic [S_W-1:0] s_reg;
    logic [P_W-1:0] pad_reg;
    logic [CW-1:0]  wp_reg;
    logic [CW-1:0]  hp_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           cfg_err_reg;

    // Window-row step S*W, again by shift-add.
    logic [AW-1:0] w_step;
    logic [AW-1:0] stride_row;
    assign w_step     = AW'(w_reg);
    assign stride_row = (s_reg[0] ? w_step : '0) + (s_reg[1] ? (w_step << 1) : '0);

    // ---------------- window walker ----------------
    logic          cnt_load;
    logic          slot;
    logic [CW-1:0] x_pos;
    logic [CW-1:0] y_pos;
    logic [AW-1:0] row_base;
    logic          win_last_c;
    logic          tile_last_c;

    assign cnt_load = (state_reg == ST_IDLE) && start;
    assign slot     = (state_reg == ST_FETCH) && !stall;

    ifm_win_cnt #(
        .ADDR_WIDTH (AW),
        .CW         (CW)
    ) u_win_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .load_base  (init_base),
        .en         (slot),
        .k          (k_reg),
        .s          (s_reg),
        .w_step     (w_step),
        .stride_row (stride_row),
        .wp         (wp_reg),
        .hp         (hp_reg),
        .x          (x_pos),
        .y          (y_pos),
        .row_base   (row_base),
        .win_last   (win_last_c),
        .tile_last  (tile_last_c)
    );

    // ---------------- padding decision and SRAM interface ----------------
    logic [CW-1:0] pad_ext;
    logic [CW-1:0] x_hi;
    logic [CW-1:0] y_hi;
    logic          in_tile;
    logic [AW-1:0] addr_c;

    assign pad_ext = CW'(pad_reg);
    assign x_hi    = CW'(w_reg) + pad_ext;
    assign y_hi    = CW'(h_reg) + pad_ext;
    assign in_tile = (x_pos >= pad_ext) && (x_pos < x_hi) &&
                     (y_pos >= pad_ext) && (y_pos < y_hi);
    assign addr_c  = row_base + AW'(x_pos) - AW'(pad_reg);

    assign sram_rd_en = slot && in_tile;
    assign sram_addr  = (state_reg == ST_FETCH) ? addr_c : '0;

    // FSM with registered status outputs; config captured on an accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            w_reg       <= '0;
            h_reg       <= '0;
            k_reg       <= '0;
            s_reg       <= '0;
            pad_reg     <= '0;
            wp_reg      <= '0;
            hp_reg      <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            cfg_err_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // Accepted even while stalled; stall only gates the datapath.
                    if (start) begin
                        w_reg       <= cfg_w;
                        h_reg       <= cfg_h;
                        k_reg       <= cfg_k;
                        s_reg       <= cfg_stride;
                        pad_reg     <= pad_in;
                        wp_reg      <= wp_in;
                        hp_reg      <= hp_in;
                        busy_reg    <= 1'b1;
                        cfg_err_reg <= !cfg_legal;
                        done_reg    <= !cfg_legal;
                        state_reg   <= cfg_legal ? ST_FETCH : ST_ERR;
                    end
                end
                ST_FETCH: begin
                    if (!stall && tile_last_c) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The final pixel leaves on the first unstalled cycle here.
                    if (!stall) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                ST_ERR: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ---------------- delivery pipe ----------------
    logic valid_reg;
    logic pad_q_reg;
    logic last_q_reg;

    // One-stage pipe matching SRAM read latency; frozen while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg  <= 1'b0;
            pad_q_reg  <= 1'b0;
            last_q_reg <= 1'b0;
        end else if (!stall) begin
            valid_reg  <= slot;
            pad_q_reg  <= slot && !in_tile;
            last_q_reg <= slot && win_last_c;
        end
    end

    assign set_ifm  = valid_reg && !stall;
    assign win_last = last_q_reg && !stall;
    assign ifm_in   = (valid_reg && !pad_q_reg) ? sram_rd_data : '0;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign cfg_err  = cfg_err_reg;

endmodule

// File: tb/tb_ifm_fetch_ctrl.sv
// Self-checking bench for ifm_fetch_ctrl: directed cases plus randomized
// tiles and stalls against a loop-based reference of the window scan.
module tb_ifm_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] cfg_base;
    logic [7:0]  cfg_w;
    logic [7:0]  cfg_h;
    logic [3:0]  cfg_k;
    logic [1:0]  cfg_stride;
`ifdef IFM_PAD_EN
    logic [1:0]  cfg_pad;
`endif
    logic        stall;
    logic        sram_rd_en;
    logic [15:0] sram_addr;
    logic [7:0]  sram_rd_data;
    logic        set_ifm;
    logic [7:0]  ifm_in;
    logic        win_last;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_rd[$];
    logic [7:0]  exp_px[$];
    bit          exp_wl[$];

    ifm_fetch_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (16),
        .DIM_W      (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_base     (cfg_base),
        .cfg_w        (cfg_w),
        .cfg_h        (cfg_h),
        .cfg_k        (cfg_k),
        .cfg_stride   (cfg_stride),
`ifdef IFM_PAD_EN
        .cfg_pad      (cfg_pad),
`endif
        .stall        (stall),
        .sram_rd_en   (sram_rd_en),
        .sram_addr    (sram_addr),
        .sram_rd_data (sram_rd_data),
        .set_ifm      (set_ifm),
        .ifm_in       (ifm_in),
        .win_last     (win_last),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM content is a fixed function of the address.
    function automatic logic [7:0] pix(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    // SRAM: data one cycle after the read, held while no read is issued.
    initial sram_rd_data = 8'h00;
    always @(posedge clk) begin
        if (sram_rd_en) sram_rd_data <= pix(sram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic drive_start(input logic [15:0] base, input int w, input int h,
                               input int k, input int s, input int p, input bit stl);
        @(posedge clk); #1;
        start      = 1'b1;
        cfg_base   = base;
        cfg_w      = 8'(w);
        cfg_h      = 8'(h);
        cfg_k      = 4'(k);
        cfg_stride = 2'(s);
`ifdef IFM_PAD_EN
        cfg_pad    = 2'(p);
`else
        if (p != 0) $display("note: padding requested without IFM_PAD_EN");
`endif
        stall      = stl;
    endtask

    task automatic run_tile(input string name, input logic [15:0] base, input int w, input int h,
                            input int k, input int s, input int p, input int stall_pct);
        int wp, hp, nwin, total, budget, cyc, n_set, n_wl, last_set, done_cyc;
        int a;
        bit got_done;
        exp_rd.delete();
        exp_px.delete();
        exp_wl.delete();
        wp = w + 2 * p;
        hp = h + 2 * p;
        nwin = 0;
        for (int r0 = 0; r0 + k <= hp; r0 += s) begin
            for (int c0 = 0; c0 + k <= wp; c0 += s) begin
                nwin++;
                for (int ky = 0; ky < k; ky++) begin
                    for (int kx = 0; kx < k; kx++) begin
                        if ((c0 + kx >= p) && (c0 + kx < w + p) && (r0 + ky >= p) && (r0 + ky < h + p)) begin
                            a = int'(base) + (r0 + ky - p) * w + (c0 + kx - p);
                            exp_rd.push_back(16'(a));
                            exp_px.push_back(pix(16'(a)));
                        end else begin
                            exp_px.push_back(8'h00);
                        end
                        exp_wl.push_back((kx == k - 1) && (ky == k - 1));
                    end
                end
            end
        end
        total = k * k * ((wp - k) / s + 1) * ((hp - k) / s + 1);
        budget = total * 20 + 50;

        drive_start(base, w, h, k, s, p, ($urandom_range(99) < stall_pct));
        cyc = 0; n_set = 0; n_wl = 0; last_set = -1; done_cyc = -1; got_done = 0;
        @(negedge clk);
        chk({name, ":rd_idle"}, 32'(sram_rd_en), 0);
        while (!got_done && cyc < budget) begin
            @(posedge clk); #1;
            start = 1'b0;
            stall = ($urandom_range(99) < stall_pct);
            cyc++;
            if (cyc == 3 && total >= 4) begin
                // a start while busy, with an illegal config, must be ignored
                start = 1'b1;
                cfg_k = 4'd0;
                cfg_w = 8'd1;
                cfg_base = 16'hDEAD;
            end
            @(negedge clk);
            if (cyc == 1) begin
                chk({name, ":busy"}, 32'(busy), 1);
                chk({name, ":cfg_err"}, 32'(cfg_err), 0);
            end
            if (stall) begin
                chk({name, ":rd_in_stall"}, 32'(sram_rd_en), 0);
                chk({name, ":set_in_stall"}, 32'(set_ifm), 0);
            end
            if (sram_rd_en) begin
                if (exp_rd.size() == 0) chk({name, ":extra_rd"}, 32'(sram_addr), 32'hFFFF_FFFF);
                else chk({name, ":rd_addr"}, 32'(sram_addr), 32'(exp_rd.pop_front()));
            end
            if (set_ifm) begin
                n_set++;
                last_set = cyc;
                if (win_last) n_wl++;
                if (exp_px.size() == 0) begin
                    chk({name, ":extra_set"}, 32'(ifm_in), 32'hFFFF_FFFF);
                end else begin
                    chk({name, ":ifm_in"}, 32'(ifm_in), 32'(exp_px.pop_front()));
                    chk({name, ":win_last"}, 32'(win_last), 32'(exp_wl.pop_front()));
                end
            end
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
        end
        chk({name, ":done_seen"}, 32'(got_done), 1);
        chk({name, ":done_latency"}, 32'(done_cyc), 32'(last_set + 1));
        chk({name, ":n_set"}, 32'(n_set), 32'(total));
        chk({name, ":n_win_last"}, 32'(n_wl), 32'(nwin));
        chk({name, ":rd_left"}, 32'(exp_rd.size()), 0);
        @(posedge clk); #1;
        start = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk({name, ":done_pulse"}, 32'(done), 0);
        chk({name, ":busy_end"}, 32'(busy), 0);
        $display("tile %s: base=%h w=%0d h=%0d k=%0d s=%0d p=%0d stall=%0d%% set_ifm=%0d windows=%0d cycles=%0d",
                 name, base, w, h, k, s, p, stall_pct, n_set, n_wl, cyc);
    endtask

    task automatic run_err(input string name, input int k, input int w, input int h, input int s);
        drive_start(16'h0100, w, h, k, s, 0, 1'b1);
        @(negedge clk);
        chk({name, ":rd"}, 32'(sram_rd_en), 0);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            stall = 1'b0;
            @(negedge clk);
            chk({name, ":rd"}, 32'(sram_rd_en), 0);
            chk({name, ":done"}, 32'(done), 32'(cyc == 1));
            chk({name, ":cfg_err"}, 32'(cfg_err), 1);
        end
        $display("err %s: k=%0d w=%0d h=%0d s=%0d cfg_err=%0b", name, k, w, h, s, cfg_err);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, ":rd_en"}, 32'(sram_rd_en), 0);
        chk({name, ":addr"}, 32'(sram_addr), 0);
        chk({name, ":set_ifm"}, 32'(set_ifm), 0);
        chk({name, ":ifm_in"}, 32'(ifm_in), 0);
        chk({name, ":win_last"}, 32'(win_last), 0);
        chk({name, ":busy"}, 32'(busy), 0);
        chk({name, ":done"}, 32'(done), 0);
        chk({name, ":cfg_err"}, 32'(cfg_err), 0);
    endtask

    initial begin
        int w, h, k, s, kmax;
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        cfg_base = '0;
        cfg_w = '0;
        cfg_h = '0;
        cfg_k = '0;
        cfg_stride = '0;
`ifdef IFM_PAD_EN
        cfg_pad = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_tile("case1", 16'h0100, 4, 4, 3, 1, 0, 0);
        run_tile("case2", 16'h0200, 5, 5, 3, 2, 0, 0);
        run_tile("case3_stall", 16'h0100, 4, 4, 3, 1, 0, 50);
        run_err("k_gt_w", 5, 4, 4, 1);
        run_err("k_zero", 0, 4, 4, 1);
        run_err("s_zero", 3, 4, 4, 0);

        // reset in the middle of a tile, then restart from base
        drive_start(16'h0400, 6, 6, 3, 1, 0, 1'b0);
        repeat (8) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        $display("mid-tile reset applied");
        run_tile("after_reset", 16'h0400, 6, 6, 3, 1, 0, 0);
        run_tile("wrap", 16'hFFF0, 6, 5, 2, 1, 0, 30);

        for (int t = 0; t < 8; t++) begin
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 8);
            kmax = (w < h) ? w : h;
            if (kmax > 5) kmax = 5;
            k = $urandom_range(1, kmax);
            s = $urandom_range(1, 3);
            run_tile($sformatf("rand%0d", t), 16'($urandom), w, h, k, s, 0, $urandom_range(0, 60));
        end

`ifdef IFM_PAD_EN
        run_tile("case6_pad", 16'h0300, 3, 3, 3, 1, 1, 0);
        run_tile("pad_stall", 16'h0500, 4, 3, 2, 2, 2, 40);
        run_tile("pad_k1", 16'h0600, 2, 2, 1, 1, 1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
